// File: rtl/apb_arb2.sv
// apb_arb2: round-robin arbiter sharing one APB completer between two APB requesters.
// Define APB_ARB_TIMEOUT_EN to force completion of ACCESS phases that stall for TIMEOUT_CYCLES.
module apb_arb2 #(
  parameter int DECODE_BITS    = 16,
  parameter int NUM_CSEL_LOG2  = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DECODE_BITS-1:0]   M0_PADDR,
  input  logic [NUM_CSEL_LOG2-1:0] M0_PSEL_BANK,
  input  logic                     M0_PSEL,
  input  logic                     M0_PENABLE,
  input  logic                     M0_PWRITE,
  input  logic [31:0]              M0_PWDATA,
  output logic [31:0]              M0_PRDATA,
  output logic                     M0_PREADY,
  input  logic [DECODE_BITS-1:0]   M1_PADDR,
  input  logic [NUM_CSEL_LOG2-1:0] M1_PSEL_BANK,
  input  logic                     M1_PSEL,
  input  logic                     M1_PENABLE,
  input  logic                     M1_PWRITE,
  input  logic [31:0]              M1_PWDATA,
  output logic [31:0]              M1_PRDATA,
  output logic                     M1_PREADY,
  output logic [DECODE_BITS-1:0]   PADDR,
  output logic [NUM_CSEL_LOG2-1:0] PSEL_BANK,
  output logic                     PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [31:0]              PWDATA,
  input  logic [31:0]              PRDATA,
  input  logic                     PREADY,
  output logic                     TIMEOUT
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic        grant_reg, grant_next;
  logic        last_grant_reg, last_grant_next;
  logic        busy, in_access, force_done, done;
  logic [31:0] rdata;
  logic        unused_penable;

  assign busy      = (state_reg != IDLE);
  assign in_access = (state_reg == ACCESS);

  // Requester PENABLE carries no information the arbiter needs.
  assign unused_penable = M0_PENABLE ^ M1_PENABLE;

`ifdef APB_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      wait_cnt_reg <= '0;
    else if (state_reg == SETUP)
      wait_cnt_reg <= '0;
    else if (in_access && !PREADY)
      wait_cnt_reg <= wait_cnt_reg + 16'd1;
  end

  // A real PREADY in the final allowed cycle takes precedence over the forced completion.
  assign force_done = in_access && !PREADY && (wait_cnt_reg == 16'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign force_done = 1'b0;
`endif

  assign done = in_access && (PREADY || force_done);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      IDLE: begin
        if (M0_PSEL || M1_PSEL) begin
          // Under contention the requester not served last wins.
          grant_next = (M0_PSEL && M1_PSEL) ? ~last_grant_reg : M1_PSEL;
          state_next = SETUP;
        end
      end
      SETUP:  state_next = ACCESS;
      ACCESS: begin
        if (done) begin
          last_grant_next = grant_reg;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign PSEL      = busy;
  assign PENABLE   = in_access;
  assign PADDR     = busy ? (grant_reg ? M1_PADDR     : M0_PADDR)     : '0;
  assign PSEL_BANK = busy ? (grant_reg ? M1_PSEL_BANK : M0_PSEL_BANK) : '0;
  assign PWRITE    = busy ? (grant_reg ? M1_PWRITE    : M0_PWRITE)    : 1'b0;
  assign PWDATA    = busy ? (grant_reg ? M1_PWDATA    : M0_PWDATA)    : '0;

  assign rdata     = force_done ? 32'hFFFF_FFFF : PRDATA;
  assign M0_PRDATA = (in_access && !grant_reg) ? rdata : '0;
  assign M1_PRDATA = (in_access &&  grant_reg) ? rdata : '0;
  assign M0_PREADY = done && !grant_reg;
  assign M1_PREADY = done &&  grant_reg;
  assign TIMEOUT   = force_done;

endmodule
